pong_score_keeper: RTL and testbench

//  Downstream consumer of the ball stage: watches BallX/BallS each frame, detects a goal
//  (ball touching the left or right playfield edge), credits the opposite player, and

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_score_keeper_serve_timer.sv | 33 +++
 rtl/pong_score_keeper.sv | 158 +++++++++++++++
 tb/tb_pong_score_keeper.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match logic and the ball stage.
//   game_state_t : match FSM states
//   player_t     : winner encoding driven on Winner
//   PF_X_MIN/MAX : playfield goal lines, shared with the ball stage
package pong_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_PLAY  = 2'd1,
    GS_SERVE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    P_NONE  = 2'd0,
    P_LEFT  = 2'd1,
    P_RIGHT = 2'd2
  } player_t;

  localparam int unsigned PF_X_MIN = 0;
  localparam int unsigned PF_X_MAX = 639;

endpackage

// File: rtl/pong_score_keeper_serve_timer.sv
// Serve delay down-counter.
//   clk        : frame clock
//   rst_n      : asynchronous active-low reset, clears the count
//   i_load     : load i_load_val (wins over decrement)
//   i_load_val : value loaded on i_load
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : count has reached zero (terminal count)
module serve_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pong_score_keeper.sv
// Pong match controller: detects goals from the ball position, keeps scores,
// holds the ball stage in reset around each serve and runs the match FSM.
//   frame_clk : one edge per frame, shared with the ball stage
//   Reset_n   : asynchronous active-low reset
//   Start     : start/restart button level (rising edge used)
//   BallX     : ball centre X
//   BallS     : ball half-size
//   BallReset : active-high hold/recentre to the ball stage
//   Score1    : left player score (scores on right goal)
//   Score2    : right player score (scores on left goal)
//   Serving   : high while serving
//   GameOver  : high once a player reached WIN_SCORE
//   Winner    : 0 none, 1 left, 2 right
//
// state    | meaning
// GS_IDLE  | waiting for the first Start edge, ball held
// GS_SERVE | ball held at centre for SERVE_DELAY frames
// GS_PLAY  | ball live, goals are scored
// GS_OVER  | match finished, scores frozen until Start edge
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned X_MIN       = PF_X_MIN,
  parameter int unsigned X_MAX       = PF_X_MAX,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [9:0]         BallX,
  input  logic [9:0]         BallS,
  output logic               BallReset,
  output logic [SCORE_W-1:0] Score1,
  output logic [SCORE_W-1:0] Score2,
  output logic               Serving,
  output logic               GameOver,
  output logic [1:0]         Winner
);

  localparam int unsigned CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [10:0]        X_MIN_11   = 11'(X_MIN);
  localparam logic [10:0]        X_MAX_11   = 11'(X_MAX);

  game_state_t        r_state, w_state_nxt;
  logic [SCORE_W-1:0] r_score1, r_score2, w_score1_nxt, w_score2_nxt;
  logic [SCORE_W-1:0] w_score1_inc, w_score2_inc;
  player_t            r_winner, w_winner_nxt;
  logic               r_start_q;
  logic               w_start_edge;
  logic               w_goal_l, w_goal_r;
  logic               w_load, w_dec, w_zero;
  logic [10:0]        w_left_line, w_right_reach;

  // 11-bit sums so X_MIN + BallS and BallX + BallS cannot wrap.
  assign w_left_line   = X_MIN_11 + {1'b0, BallS};
  assign w_right_reach = {1'b0, BallX} + {1'b0, BallS};
  assign w_goal_l      = ({1'b0, BallX} <= w_left_line);
  assign w_goal_r      = (w_right_reach >= X_MAX_11);

  assign w_start_edge  = Start & ~r_start_q;
  assign w_score1_inc  = r_score1 + SCORE_W'(1);
  assign w_score2_inc  = r_score2 + SCORE_W'(1);
  assign w_dec         = (r_state == GS_SERVE);

  serve_timer #(.W(CNT_W)) u_serve_timer (
    .clk        (frame_clk),
    .rst_n      (Reset_n),
    .i_load     (w_load),
    .i_load_val (SERVE_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= GS_IDLE;
      r_score1  <= '0;
      r_score2  <= '0;
      r_winner  <= P_NONE;
      // Start held through reset must not look like a press.
      r_start_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_score1  <= w_score1_nxt;
      r_score2  <= w_score2_nxt;
      r_winner  <= w_winner_nxt;
      r_start_q <= Start;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_score1_nxt = r_score1;
    w_score2_nxt = r_score2;
    w_winner_nxt = r_winner;
    w_load       = 1'b0;
    case (r_state)
      GS_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = GS_SERVE;
          w_load      = 1'b1;
        end
      end
      GS_SERVE: begin
        if (w_zero) begin
          w_state_nxt = GS_PLAY;
        end
      end
      GS_PLAY: begin
        // Left goal has priority when the ball spans the whole field.
        if (w_goal_l) begin
          w_score2_nxt = w_score2_inc;
          if (w_score2_inc == WIN_S) begin
            w_state_nxt  = GS_OVER;
            w_winner_nxt = P_RIGHT;
          end else begin
            w_state_nxt = GS_SERVE;
            w_load      = 1'b1;
          end
        end else if (w_goal_r) begin
          w_score1_nxt = w_score1_inc;
          if (w_score1_inc == WIN_S) begin
            w_state_nxt  = GS_OVER;
            w_winner_nxt = P_LEFT;
          end else begin
            w_state_nxt = GS_SERVE;
            w_load      = 1'b1;
          end
        end
      end
      GS_OVER: begin
        if (w_start_edge) begin
          w_score1_nxt = '0;
          w_score2_nxt = '0;
          w_winner_nxt = P_NONE;
          w_state_nxt  = GS_SERVE;
          w_load       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = GS_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; no input-to-output path.
  assign BallReset = (r_state != GS_PLAY);
  assign Serving   = (r_state == GS_SERVE);
  assign GameOver  = (r_state == GS_OVER);
  assign Score1    = r_score1;
  assign Score2    = r_score2;
  assign Winner    = r_winner;

endmodule

// File: tb/tb_pong_score_keeper.sv
module tb_pong_score_keeper;

  localparam int WIN = 3;
  localparam int SD  = 4;
  localparam int XMX = 639;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [9:0] BallX;
  logic [9:0] BallS;
  logic       BallReset;
  logic [3:0] Score1;
  logic [3:0] Score2;
  logic       Serving;
  logic       GameOver;
  logic [1:0] Winner;

  int checks = 0;
  int errors = 0;

  pong_score_keeper #(
    .X_MIN(0), .X_MAX(XMX), .SCORE_W(4), .WIN_SCORE(WIN), .SERVE_DELAY(SD)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .BallX     (BallX),
    .BallS     (BallS),
    .BallReset (BallReset),
    .Score1    (Score1),
    .Score2    (Score2),
    .Serving   (Serving),
    .GameOver  (GameOver),
    .Winner    (Winner)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       start;
    int         x;
    int         s;
    logic       br;
    logic       sv;
    logic       go;
    int         win;
    int         s1;
    int         s2;
  } vec_t;

  vec_t vecs[39];

  function automatic vec_t mk(logic st, int x, int s, logic br, logic sv, logic go,
                              int win, int s1, int s2);
    vec_t v;
    v.start = st; v.x = x; v.s = s; v.br = br; v.sv = sv; v.go = go;
    v.win = win; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic br, logic sv, logic go, int win, int s1, int s2);
    chk({tag, " BallReset"}, int'(BallReset), int'(br));
    chk({tag, " Serving"},   int'(Serving),   int'(sv));
    chk({tag, " GameOver"},  int'(GameOver),  int'(go));
    chk({tag, " Winner"},    int'(Winner),    win);
    chk({tag, " Score1"},    int'(Score1),    s1);
    chk({tag, " Score2"},    int'(Score2),    s2);
  endtask

  task automatic frame(logic st, int x, int s);
    @(negedge frame_clk);
    Start = st;
    BallX = 10'(x);
    BallS = 10'(s);
    @(posedge frame_clk);
    #1;
  endtask

  // Behavioural reference: match phase, frames of serve still to show, scores.
  int  m_phase;         // 0 idle, 1 serve, 2 play, 3 over
  int  m_serve_left;
  int  m_p1, m_p2, m_win;
  logic m_prev_start;

  function automatic void model_reset();
    m_phase = 0; m_serve_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_prev_start = 1'b1;
  endfunction

  function automatic void model_step(logic st, int x, int s);
    bit pressed = st && !m_prev_start;
    bit gl = (x <= 0 + s);
    bit gr = (x + s >= XMX);
    m_prev_start = st;
    if (m_phase == 0) begin
      if (pressed) begin m_phase = 1; m_serve_left = SD; end
    end else if (m_phase == 1) begin
      m_serve_left--;
      if (m_serve_left == 0) m_phase = 2;
    end else if (m_phase == 2) begin
      if (gl) m_p2++;
      else if (gr) m_p1++;
      if (gl || gr) begin
        if (m_p1 == WIN)      begin m_phase = 3; m_win = 1; end
        else if (m_p2 == WIN) begin m_phase = 3; m_win = 2; end
        else begin m_phase = 1; m_serve_left = SD; end
      end
    end else begin
      if (pressed) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; m_phase = 1; m_serve_left = SD;
      end
    end
  endfunction

  initial begin
    logic st;
    int   x, s, r;

    vecs[0]  = mk(1, 320,   4, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 320,   4, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 320,   4, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 320,   4, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 320,   4, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1,   3,   4, 1, 1, 0, 0, 0, 1);
    vecs[10] = mk(1,   3,   4, 1, 1, 0, 0, 0, 1);
    vecs[11] = mk(1,   3,   4, 1, 1, 0, 0, 0, 1);
    vecs[12] = mk(1,   3,   4, 1, 1, 0, 0, 0, 1);
    vecs[13] = mk(1, 320,   4, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 636,   4, 1, 1, 0, 0, 1, 1);
    vecs[15] = mk(1, 636,   4, 1, 1, 0, 0, 1, 1);
    vecs[16] = mk(1, 636,   4, 1, 1, 0, 0, 1, 1);
    vecs[17] = mk(1, 320,   4, 1, 1, 0, 0, 1, 1);
    vecs[18] = mk(1, 320,   4, 0, 0, 0, 0, 1, 1);
    vecs[19] = mk(1, 320, 400, 1, 1, 0, 0, 1, 2);
    vecs[20] = mk(1, 320,   4, 1, 1, 0, 0, 1, 2);
    vecs[21] = mk(1, 320,   4, 1, 1, 0, 0, 1, 2);
    vecs[22] = mk(1, 320,   4, 1, 1, 0, 0, 1, 2);
    vecs[23] = mk(1, 320,   4, 0, 0, 0, 0, 1, 2);
    vecs[24] = mk(1, 635,   4, 1, 1, 0, 0, 2, 2);
    vecs[25] = mk(1, 320,   4, 1, 1, 0, 0, 2, 2);
    vecs[26] = mk(1, 320,   4, 1, 1, 0, 0, 2, 2);
    vecs[27] = mk(1, 320,   4, 1, 1, 0, 0, 2, 2);
    vecs[28] = mk(1, 320,   4, 0, 0, 0, 0, 2, 2);
    vecs[29] = mk(1, 636,   4, 1, 0, 1, 1, 3, 2);
    vecs[30] = mk(0, 636,   4, 1, 0, 1, 1, 3, 2);
    vecs[31] = mk(0,   3,   4, 1, 0, 1, 1, 3, 2);
    vecs[32] = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[33] = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[34] = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[35] = mk(1, 320,   4, 1, 1, 0, 0, 0, 0);
    vecs[36] = mk(1, 320,   4, 0, 0, 0, 0, 0, 0);
    vecs[37] = mk(0, 320,   4, 0, 0, 0, 0, 0, 0);
    vecs[38] = mk(1, 320,   4, 0, 0, 0, 0, 0, 0);

    Reset_n = 1'b0;
    Start   = 1'b1;
    BallX   = 10'd320;
    BallS   = 10'd4;
    #1;
    check_all("reset", 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 39; i++) begin
      frame(vecs[i].start, vecs[i].x, vecs[i].s);
      check_all($sformatf("vec%0d", i), vecs[i].br, vecs[i].sv, vecs[i].go,
                vecs[i].win, vecs[i].s1, vecs[i].s2);
    end

    // Async reset mid-serve: score a left goal, run one serve frame, then reset.
    frame(1, 3, 4);
    check_all("pre_rst_a", 1, 1, 0, 0, 0, 1);
    frame(1, 320, 4);
    check_all("pre_rst_b", 1, 1, 0, 0, 0, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all("async_rst", 1, 0, 0, 0, 0, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    frame(1, 320, 4);
    check_all("post_rst_idle", 1, 0, 0, 0, 0, 0);

    // Randomized play against the reference model.
    model_reset();
    model_step(1, 320, 4);
    st = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) st = ~st;
      r = int'($urandom_range(0, 3));
      if (r == 0)      x = int'($urandom_range(0, 12));
      else if (r == 1) x = int'($urandom_range(626, 639));
      else             x = int'($urandom_range(13, 625));
      s = ($urandom_range(0, 31) == 0) ? int'($urandom_range(300, 700))
                                       : int'($urandom_range(1, 8));
      model_step(st, x, s);
      frame(st, x, s);
      check_all($sformatf("rnd%0d", n), m_phase != 2, m_phase == 1, m_phase == 3,
                m_win, m_p1, m_p2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
